// File: rtl/fnd_display_ctrl.sv
// fnd_display_ctrl: binary-to-BCD (sequential double-dabble) plus 4-digit multiplexed 7-segment driver
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   data       - binary value to display (DATA_W bits)
//   data_valid - one-cycle strobe, sampled while busy=0
//   busy       - conversion in progress, data_valid ignored while high
//   ovf        - last accepted value exceeded 9999 and was saturated
//   fndCom     - active-low one-hot digit enables, bit 0 = ones digit
//   fndFont    - active-low segments {dp,g,f,e,d,c,b,a}
module fnd_display_ctrl #(
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              busy,
    output logic              ovf,
    output logic [3:0]        fndCom,
    output logic [7:0]        fndFont
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state;
    logic [DATA_W-1:0]  bin;
    logic [15:0]        bcd, bcd_adj, disp;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      pre;
    logic [1:0]         idx;
    logic [15+DATA_W:0] sh;
    logic [3:0]         cur;
    logic               blank, over, tc;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    assign sh    = {bcd_adj, bin} << 1;
    assign over  = 32'(data) > 32'd9999;
    assign cur   = disp[{idx, 2'b00} +: 4];
    // a digit is a leading zero when it and every digit above it are zero
    assign blank = BLANK_LZ != 0 && idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'd0;
    assign tc    = pre == PW'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            disp  <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (data_valid) begin
                    bin   <= over ? DATA_W'(9999) : data;
                    ovf   <= over;
                    bcd   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= sh;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) state <= DONE;
                end
                DONE: begin
                    disp  <= bcd;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre     <= '0;
            idx     <= '0;
            fndCom  <= 4'hF;
            fndFont <= 8'hFF;
        end else begin
            pre     <= tc ? '0 : pre + 1'b1;
            idx     <= tc ? idx + 1'b1 : idx;
            fndCom  <= ~(4'b0001 << idx);
            fndFont <= {~(ovf && idx == 2'd3), blank ? 7'h7F : seg7(cur)};
        end
    end
endmodule

// File: tb/tb_fnd_display_ctrl.sv
// tb_fnd_display_ctrl: directed bench with a cycle model of value/scan behaviour for fnd_display_ctrl
module tb_fnd_display_ctrl;
    logic        clk, reset, data_valid, armed;
    logic [13:0] data;
    logic        busy, ovf, busy0, ovf0;
    logic [3:0]  fndCom, fndCom0;
    logic [7:0]  fndFont, fndFont0;
    int          checks, errors;
    int          n, m_busy, m_disp, m_pend;
    logic        m_ovf;
    logic [3:0]  e_com;
    logic [7:0]  e_font1, e_font0;

    fnd_display_ctrl #(.DATA_W(14), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .busy(busy), .ovf(ovf), .fndCom(fndCom), .fndFont(fndFont));

    fnd_display_ctrl #(.DATA_W(14), .SCAN_DIV(4), .BLANK_LZ(0)) dut0 (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .busy(busy0), .ovf(ovf0), .fndCom(fndCom0), .fndFont(fndFont0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font(input int v, input int k, input logic ov, input int blz);
        int p;
        logic [7:0] f;
        p = k == 0 ? 1 : k == 1 ? 10 : k == 2 ? 100 : 1000;
        case ((v / p) % 10)
            0: f = 8'hC0;
            1: f = 8'hF9;
            2: f = 8'hA4;
            3: f = 8'hB0;
            4: f = 8'h99;
            5: f = 8'h92;
            6: f = 8'h82;
            7: f = 8'hF8;
            8: f = 8'h80;
            default: f = 8'h90;
        endcase
        if (blz != 0 && k > 0 && v < p) f = 8'hFF;
        if (k == 3 && ov) f[7] = 1'b0;
        return f;
    endfunction

    // n counts edges since reset release; digit k is selected for SCAN_DIV edges in turn,
    // and the outputs show the digit/value as they stood before each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= 0; m_busy <= 0; m_disp <= 0; m_pend <= 0; m_ovf <= 1'b0;
            e_com <= 4'hF; e_font1 <= 8'hFF; e_font0 <= 8'hFF;
        end else begin
            e_com   <= ~(4'b0001 << ((n / 4) % 4));
            e_font1 <= font(m_disp, (n / 4) % 4, m_ovf, 1);
            e_font0 <= font(m_disp, (n / 4) % 4, m_ovf, 0);
            n       <= n + 1;
            if (data_valid && m_busy == 0) begin
                m_busy <= 15;
                m_ovf  <= int'(data) > 9999;
                m_pend <= int'(data) > 9999 ? 9999 : int'(data);
            end else if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_disp <= m_pend;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (armed) begin
        chk("com", fndCom, e_com);
        chk("com0", fndCom0, e_com);
        chk("font", fndFont, e_font1);
        chk("font0", fndFont0, e_font0);
        chk("busy", busy, m_busy != 0);
        chk("ovf", ovf, m_ovf);
    end

    task automatic send(input int v);
        @(negedge clk);
        data = 14'(v);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("busy_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic lit(input logic [3:0] c, input logic [7:0] f1, input logic [7:0] f0);
        int t = 0;
        while (fndCom != c && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("lit_com", fndCom, c);
        chk("lit_font", fndFont, f1);
        chk("lit_font0", fndFont0, f0);
    endtask

    initial begin
        int cnt;
        checks = 0; errors = 0; armed = 1'b0;
        reset = 1'b1; data = '0; data_valid = 1'b0;
        #2 reset = 1'b0;
        armed = 1'b1;
        #1 chk("rst_com", fndCom, 4'hF);
        chk("rst_font", fndFont, 8'hFF);
        #30;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("first_com", fndCom, 4'b1110);
        lit(4'b1101, 8'hFF, 8'hC0);
        lit(4'b0111, 8'hFF, 8'hC0);
        lit(4'b1110, 8'hC0, 8'hC0);

        send(1234);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len", cnt, 15);
        @(negedge clk);
        lit(4'b1110, 8'h99, 8'h99);
        lit(4'b1101, 8'hB0, 8'hB0);
        lit(4'b1011, 8'hA4, 8'hA4);
        lit(4'b0111, 8'hF9, 8'hF9);
        chk("ovf_1234", ovf, 0);

        send(12000);
        wait_done();
        chk("ovf_12000", ovf, 1);
        lit(4'b1110, 8'h90, 8'h90);
        lit(4'b1011, 8'h90, 8'h90);
        lit(4'b0111, 8'h10, 8'h10);

        send(7);
        repeat (2) @(negedge clk);
        send(5);
        wait_done();
        lit(4'b1110, 8'hF8, 8'hF8);
        lit(4'b1101, 8'hFF, 8'hC0);
        lit(4'b0111, 8'hFF, 8'hC0);
        chk("ovf_7", ovf, 0);

        @(negedge clk);
        data = 14'd42;
        data_valid = 1'b1;
        repeat (17) @(negedge clk);
        data_valid = 1'b0;
        chk("retrigger_busy", busy, 1);
        wait_done();
        lit(4'b1110, 8'hA4, 8'hA4);
        lit(4'b1101, 8'h99, 8'h99);

        send(305);
        wait_done();
        lit(4'b1110, 8'h92, 8'h92);
        lit(4'b1101, 8'hC0, 8'hC0);
        lit(4'b1011, 8'hB0, 8'hB0);
        lit(4'b0111, 8'hFF, 8'hC0);

        send(1234);
        wait_done();
        lit(4'b1011, 8'hA4, 8'hA4);
        send(777);
        repeat (5) @(negedge clk);
        #3 reset = 1'b0;
        #1 chk("abort_com", fndCom, 4'hF);
        chk("abort_font", fndFont, 8'hFF);
        chk("abort_busy", busy, 0);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_busy", busy, 0);
        lit(4'b1110, 8'hC0, 8'hC0);
        lit(4'b1011, 8'hFF, 8'hC0);

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
